apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
Parametrised APB4 completer fronting a bank of NUM_REGS memory-mapped 32-bit (DATA_WIDTH) registers, driven by the team's APB bus signals.
Adds configurable wait states, byte-strobe writes, read-only status registers, privilege checking and error response on illegal accesses.
Sits between the APB bus and block-level control/status logic; register contents are exported flat on reg_q, and hardware status is imported on hw_status.

Parameters:
ADDR_WIDTH, 16, PADDR width in bits.
DATA_WIDTH, 32, data width; must be 8, 16 or 32. Localparam PSTRB_WIDTH = DATA_WIDTH/8.
NUM_REGS, 16, register count, 1..256.
WAIT_STATES, 0, PREADY-low cycles inserted in every ACCESS phase, 0..15.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from hw_status.
PRIV_ONLY, 0, 1 = accesses with PPROT[0]=0 are rejected.
RESET_VAL, 0, DATA_WIDTH-bit reset value of every RW register.

Ports:
clk  input  1  bus clock, rising edge
PRESETn  input  1  asynchronous active-low reset
PADDR  input  ADDR_WIDTH  byte address
PPROT  input  3  protection attributes; only bit 0 is used
PSELx  input  1  completer select
PENABLE  input  1  access phase
PWRITE  input  1  1 = write
PWDATA  input  DATA_WIDTH  write data
PSTRB  input  PSTRB_WIDTH  write byte lanes
PRDATA  output  DATA_WIDTH  read data
PSLVERR  output  1  error response
PREADY  output  1  transfer complete
reg_q  output  NUM_REGS*DATA_WIDTH  RW register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
hw_status  input  NUM_REGS*DATA_WIDTH  read values for RO registers; same layout as reg_q
prot_err  output  1  sticky protocol-violation flag (optional feature)

Behaviour:
- Reset: clk is the single clock; PRESETn is asynchronous and active-low.
  - While PRESETn=0: PRDATA=0, PSLVERR=0, PREADY=0, prot_err=0, FSM in IDLE, wait counter=0, all RW registers=RESET_VAL.
  - A mid-transfer reset aborts the transfer with no register update.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSELx=1 and PENABLE=0.
  - SETUP: latch the address index and decode the error.
    - -> ACCESS when PENABLE=1.
    - Stays in SETUP if PENABLE=0 and PSELx=1.
    - -> IDLE if PSELx=0.
  - ACCESS: wait counter counts 0..WAIT_STATES.
    - PREADY=1 only in the cycle where counter==WAIT_STATES. WAIT_STATES=0 gives a zero-wait completion in the first ACCESS cycle.
    - After completion: -> SETUP if PSELx=1 and PENABLE=0 (back-to-back transfer), else -> IDLE.
- Outputs: PREADY, PRDATA and PSLVERR are registered.
  - PREADY=0 outside the completing cycle.
  - PRDATA=0 except in a completing non-error read.
  - PSLVERR is meaningful only while PREADY=1 and is 0 otherwise.
- Address decode: idx = PADDR[ADDR_WIDTH-1:log2(PSTRB_WIDTH)]. Error (PSLVERR=1 on completion) if any of:
  - PADDR is not aligned to PSTRB_WIDTH;
  - idx >= NUM_REGS;
  - PRIV_ONLY=1 and PPROT[0]=0;
  - write to a register with its RO_MASK bit set.
- Writes: committed on the completing cycle, only if there is no error.
  - Byte lane k is updated only when PSTRB[k]=1.
  - PSTRB=0 completes as OKAY with no change.
  - An errored write never modifies state.
- Reads:
  - RW register returns reg_q content; RO register returns hw_status sampled in the completing cycle.
  - PSTRB is ignored on reads.
  - An errored read returns PRDATA=0.
- Simultaneous events: a register written in cycle N is visible on reg_q in cycle N+1. A read issued back-to-back after a write to the same register returns the new value.
- PADDR, PWRITE, PWDATA and PSTRB are sampled in the completing cycle. Changes during ACCESS are a protocol violation; see the optional feature.

Optional Feature:
APB_REGFILE_PROTCHK_EN
- Defined: a checker sets prot_err (sticky until PRESETn) on any of:
  - PENABLE=1 while in IDLE;
  - PADDR, PWRITE or PWDATA changing between SETUP and completion;
  - PSELx dropping while in ACCESS with PREADY=0.
  - The transfer itself proceeds unchanged.
- Undefined: checker logic is absent and prot_err is tied 0.

Test Plan:
- Reset: assert PRESETn=0 mid-write with WAIT_STATES=2 -> PREADY=0, PSLVERR=0, PRDATA=0 immediately; the target register is still RESET_VAL after release.
- Zero-wait write then read: write 0xDEADBEEF, PSTRB=4'hF to 0x0004, then read 0x0004 -> both complete in the first ACCESS cycle, PSLVERR=0, PRDATA=0xDEADBEEF, reg_q[63:32]=0xDEADBEEF.
- Wait states and strobes: WAIT_STATES=3; register holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 -> PREADY low for 3 ACCESS cycles then high; readback=0x11BB33DD.
- Errors: read 0x0040 with NUM_REGS=16 -> PSLVERR=1, PRDATA=0. Write to 0x0002 -> PSLVERR=1, no change. Write to an RO register -> PSLVERR=1. PRIV_ONLY=1 with PPROT=3'b000 -> PSLVERR=1.
- RO read: RO_MASK bit 3 set, hw_status word 3=0x0000CAFE; read 0x000C -> PRDATA=0x0000CAFE, PSLVERR=0.
- Protocol check (macro defined): change PADDR from 0x0 to 0x4 during a waited ACCESS -> prot_err=1 and stays 1 until reset; with the macro undefined, prot_err=0.

Source files
------------

// File: rtl/apb_regfile_slave_if.sv
// APB4 bus bundle for apb_regfile_slave: requester drives the request
// signals through the master modport, the register file answers through
// the slave modport.
interface apb_regfile_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]  PADDR;
    logic [2:0]             PPROT;
    logic                   PSELx;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [DATA_WIDTH-1:0]  PWDATA;
    logic [PSTRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]  PRDATA;
    logic                   PSLVERR;
    logic                   PREADY;

    modport master (
        output PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PSLVERR, PREADY
    );

    modport slave (
        input  PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PSLVERR, PREADY
    );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB4 completer in front of NUM_REGS memory-mapped registers.
// Supports programmable wait states, byte-strobe writes, read-only status
// words taken from hw_status, privileged-only access and error responses.
// Optional protocol checker: define APB_REGFILE_PROTCHK_EN to build the
// sticky prot_err flag; otherwise prot_err is tied low.
//
// Response registers (PREADY/PRDATA/PSLVERR) are loaded on the edge that
// enters the completing ACCESS cycle, so a zero-wait transfer completes in
// the first ACCESS cycle while the outputs still come straight from flops.
// The FSM state names the phase the bus was last seen in.
module apb_regfile_slave #(
    parameter int                   ADDR_WIDTH  = 16,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_REGS    = 16,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter bit                   PRIV_ONLY   = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           PRESETn,
    apb_regfile_slave_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic                           prot_err
);
    localparam int         PSTRB_WIDTH = DATA_WIDTH / 8;
    localparam int         IDX_LSB     = $clog2(PSTRB_WIDTH);
    localparam logic [3:0] WAIT_LAST   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  ready_q;
    logic                  slverr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  priv_fail;
    logic                  ro_hit;
    logic                  access_err;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  load_resp;
    logic                  commit;
    logic                  unused_prot;

    // Only PPROT[0] (privileged) matters to this block.
    assign unused_prot = ^bus.PPROT[2:1];

    assign bus.PREADY  = ready_q;
    assign bus.PSLVERR = slverr_q;
    assign bus.PRDATA  = rdata_q;

    // Decode the live address: word index, error conditions and read value
    always_comb begin
        word_addr    = bus.PADDR >> IDX_LSB;
        misaligned   = (bus.PADDR & ADDR_WIDTH'(PSTRB_WIDTH - 1)) != '0;
        out_of_range = word_addr >= ADDR_WIDTH'(NUM_REGS);
        priv_fail    = PRIV_ONLY && !bus.PPROT[0];
        ro_hit       = 1'b0;
        rd_value     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_addr == ADDR_WIDTH'(i)) begin
                ro_hit   = RO_MASK[i];
                rd_value = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
        access_err = misaligned || out_of_range || priv_fail || (bus.PWRITE && ro_hit);
    end

    // Decide whether the next cycle is the completing ACCESS cycle
    always_comb begin
        load_resp = 1'b0;
        if (bus.PSELx && !bus.PENABLE) begin
            load_resp = (WAIT_LAST == 4'd0);
        end else if (bus.PSELx && bus.PENABLE && state != IDLE && !ready_q) begin
            load_resp = (wait_cnt + 4'd1 == WAIT_LAST);
        end
    end

    // A write lands on the edge that ends its completing cycle, error-free only
    assign commit = ready_q && bus.PSELx && bus.PENABLE && bus.PWRITE &&
                    !access_err && (state != IDLE);

    // Transfer FSM with wait counter and registered response
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q  <= load_resp;
            slverr_q <= load_resp && access_err;
            rdata_q  <= (load_resp && !bus.PWRITE && !access_err) ? rd_value : '0;
            case (state)
                IDLE: begin
                    if (bus.PSELx && !bus.PENABLE) begin
                        state    <= SETUP;
                        wait_cnt <= '0;
                    end
                end
                SETUP, ACCESS: begin
                    if (!bus.PSELx) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (!bus.PENABLE) begin
                        state    <= SETUP;
                        wait_cnt <= '0;
                    end else if (ready_q) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        state    <= ACCESS;
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Register bank: byte-lane writes on completion, reset to RESET_VAL
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (word_addr == ADDR_WIDTH'(i)) begin
                    for (int k = 0; k < PSTRB_WIDTH; k++) begin
                        if (bus.PSTRB[k]) begin
                            regs[i][k*8 +: 8] <= bus.PWDATA[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_export
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

`ifdef APB_REGFILE_PROTCHK_EN
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  prot_err_q;

    // Capture setup-phase attributes and flag protocol violations (sticky)
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            prot_err_q <= 1'b0;
        end else begin
            if (bus.PSELx && !bus.PENABLE) begin
                addr_q  <= bus.PADDR;
                write_q <= bus.PWRITE;
                wdata_q <= bus.PWDATA;
            end
            if ((state == IDLE && bus.PENABLE) ||
                (state != IDLE && bus.PSELx && bus.PENABLE &&
                 (bus.PADDR != addr_q || bus.PWRITE != write_q || bus.PWDATA != wdata_q)) ||
                (state == ACCESS && !bus.PSELx && !ready_q)) begin
                prot_err_q <= 1'b1;
            end
        end
    end

    assign prot_err = prot_err_q;
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave. Three instances cover the
// configurations of interest:
//   dut_a: zero wait states, register 3 read-only (hw_status word 3 = 0xCAFE)
//   dut_b: three wait states
//   dut_c: two wait states, privileged-only, RESET_VAL 0x12345678
`timescale 1ns/1ps
module tb_apb_regfile_slave;

`ifdef APB_REGFILE_PROTCHK_EN
    localparam logic [31:0] EXP_PROT = 32'd1;
`else
    localparam logic [31:0] EXP_PROT = 32'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rstn;
    logic [2:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [15:0]  paddr;
    logic [2:0]   pprot;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [511:0] hw_a, hw_b, hw_c;
    logic [511:0] regs_a, regs_b, regs_c;
    logic         perr_a, perr_b, perr_c;

    apb_regfile_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
    apb_regfile_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_b ();
    apb_regfile_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_c ();

    assign bus_a.PADDR = paddr;  assign bus_a.PPROT = pprot;  assign bus_a.PWRITE = pwrite;
    assign bus_a.PWDATA = pwdata; assign bus_a.PSTRB = pstrb;
    assign bus_a.PSELx = psel[0]; assign bus_a.PENABLE = penable & psel[0];
    assign bus_b.PADDR = paddr;  assign bus_b.PPROT = pprot;  assign bus_b.PWRITE = pwrite;
    assign bus_b.PWDATA = pwdata; assign bus_b.PSTRB = pstrb;
    assign bus_b.PSELx = psel[1]; assign bus_b.PENABLE = penable & psel[1];
    assign bus_c.PADDR = paddr;  assign bus_c.PPROT = pprot;  assign bus_c.PWRITE = pwrite;
    assign bus_c.PWDATA = pwdata; assign bus_c.PSTRB = pstrb;
    assign bus_c.PSELx = psel[2]; assign bus_c.PENABLE = penable & psel[2];

    apb_regfile_slave #(.WAIT_STATES(0), .RO_MASK(16'h0008)) dut_a (
        .clk(clk), .PRESETn(rstn[0]), .bus(bus_a),
        .reg_q(regs_a), .hw_status(hw_a), .prot_err(perr_a));
    apb_regfile_slave #(.WAIT_STATES(3)) dut_b (
        .clk(clk), .PRESETn(rstn[1]), .bus(bus_b),
        .reg_q(regs_b), .hw_status(hw_b), .prot_err(perr_b));
    apb_regfile_slave #(.WAIT_STATES(2), .PRIV_ONLY(1'b1), .RESET_VAL(32'h1234_5678)) dut_c (
        .clk(clk), .PRESETn(rstn[2]), .bus(bus_c),
        .reg_q(regs_c), .hw_status(hw_c), .prot_err(perr_c));

    logic [2:0]  rdy;
    logic [2:0]  slverr;
    logic [31:0] rdat [3];
    assign rdy    = {bus_c.PREADY, bus_b.PREADY, bus_a.PREADY};
    assign slverr = {bus_c.PSLVERR, bus_b.PSLVERR, bus_a.PSLVERR};
    assign rdat[0] = bus_a.PRDATA;
    assign rdat[1] = bus_b.PRDATA;
    assign rdat[2] = bus_c.PRDATA;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at posedge+1 inside an ACCESS phase; returns in the completing cycle.
    task automatic wait_ready(input int d, output int waits);
        waits = 0;
        while (rdy[d] !== 1'b1 && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        check("ready_seen", 32'(rdy[d]), 32'd1);
    endtask

    // One complete transfer, entered and left at posedge+1 so calls chain back-to-back.
    task automatic xfer(input int d, input logic [15:0] addr, input logic wr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rd, output logic err, output int waits);
        psel    = 3'b001 << d;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        wait_ready(d, waits);
        rd  = rdat[d];
        err = slverr[d];
        @(posedge clk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          w;

        rstn = 3'b000; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
        hw_a = '0; hw_b = '0; hw_c = '0;
        hw_a[3*32 +: 32] = 32'h0000_CAFE;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 32'(rdy), 32'd0);
        check("rst_pslverr", 32'(slverr), 32'd0);
        check("rst_prdata_a", rdat[0], 32'd0);
        check("rst_reg_c2", regs_c[2*32 +: 32], 32'h1234_5678);
        check("rst_prot_err", {29'd0, perr_c, perr_b, perr_a}, 32'd0);
        rstn = 3'b111;
        @(posedge clk); #1;

        // Zero-wait write, then back-to-back read of the same register
        xfer(0, 16'h0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, err, w);
        check("a_wr_waits", w, 0);
        check("a_wr_err", 32'(err), 32'd0);
        check("a_reg_q1", regs_a[63:32], 32'hDEAD_BEEF);
        xfer(0, 16'h0004, 1'b0, 32'd0, 4'h0, 3'b000, rd, err, w);
        check("a_rd_waits", w, 0);
        check("a_rd_data", rd, 32'hDEAD_BEEF);
        check("a_rd_err", 32'(err), 32'd0);

        // Wait states and byte strobes
        xfer(1, 16'h0008, 1'b1, 32'h1122_3344, 4'hF, 3'b000, rd, err, w);
        check("b_wr_waits", w, 3);
        xfer(1, 16'h0008, 1'b1, 32'hAABB_CCDD, 4'b0101, 3'b000, rd, err, w);
        check("b_strb_waits", w, 3);
        check("b_strb_err", 32'(err), 32'd0);
        xfer(1, 16'h0008, 1'b0, 32'd0, 4'h0, 3'b000, rd, err, w);
        check("b_strb_rd", rd, 32'h11BB_33DD);
        check("b_rd_waits", w, 3);
        xfer(1, 16'h0008, 1'b1, 32'hFFFF_FFFF, 4'h0, 3'b000, rd, err, w);
        check("b_nostrb_err", 32'(err), 32'd0);
        check("b_nostrb_reg", regs_b[2*32 +: 32], 32'h11BB_33DD);

        // Error responses and read-only register
        xfer(0, 16'h0040, 1'b0, 32'd0, 4'h0, 3'b000, rd, err, w);
        check("a_oor_err", 32'(err), 32'd1);
        check("a_oor_data", rd, 32'd0);
        xfer(0, 16'h0002, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, err, w);
        check("a_misalign_err", 32'(err), 32'd1);
        check("a_misalign_reg0", regs_a[31:0], 32'd0);
        xfer(0, 16'h000C, 1'b1, 32'h1111_1111, 4'hF, 3'b000, rd, err, w);
        check("a_ro_wr_err", 32'(err), 32'd1);
        check("a_ro_wr_reg3", regs_a[3*32 +: 32], 32'd0);
        xfer(0, 16'h000C, 1'b0, 32'd0, 4'h0, 3'b000, rd, err, w);
        check("a_ro_rd_data", rd, 32'h0000_CAFE);
        check("a_ro_rd_err", 32'(err), 32'd0);

        // Privileged-only instance
        xfer(2, 16'h0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b000, rd, err, w);
        check("c_unpriv_wr_err", 32'(err), 32'd1);
        check("c_unpriv_waits", w, 2);
        check("c_unpriv_reg0", regs_c[31:0], 32'h1234_5678);
        xfer(2, 16'h0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b001, rd, err, w);
        check("c_priv_wr_err", 32'(err), 32'd0);
        check("c_priv_reg0", regs_c[31:0], 32'hA5A5_A5A5);
        xfer(2, 16'h0000, 1'b0, 32'd0, 4'h0, 3'b000, rd, err, w);
        check("c_unpriv_rd_err", 32'(err), 32'd1);
        check("c_unpriv_rd_data", rd, 32'd0);

        // Reset asserted in the completing cycle of a waited write
        psel = 3'b100; penable = 1'b0; paddr = 16'h0008; pwrite = 1'b1;
        pwdata = 32'hFFFF_0000; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("c_pre_rst_ready", 32'(rdy[2]), 32'd1);
        rstn[2] = 1'b0;
        #1;
        check("c_rst_ready", 32'(rdy[2]), 32'd0);
        check("c_rst_slverr", 32'(slverr[2]), 32'd0);
        check("c_rst_prdata", rdat[2], 32'd0);
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        rstn[2] = 1'b1;
        check("c_rst_reg2", regs_c[2*32 +: 32], 32'h1234_5678);
        check("c_rst_reg0", regs_c[31:0], 32'h1234_5678);
        @(posedge clk); #1;
        xfer(2, 16'h0008, 1'b0, 32'd0, 4'h0, 3'b001, rd, err, w);
        check("c_post_rst_rd", rd, 32'h1234_5678);
        check("c_post_rst_waits", w, 2);

        // Address changed mid-ACCESS on the waited instance
        psel = 3'b010; penable = 1'b0; paddr = 16'h0000; pwrite = 1'b0;
        pwdata = 32'd0; pstrb = 4'h0; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        paddr = 16'h0004;
        wait_ready(1, w);
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        check("b_prot_err", 32'(perr_b), EXP_PROT);
        xfer(1, 16'h0000, 1'b0, 32'd0, 4'h0, 3'b000, rd, err, w);
        check("b_prot_sticky", 32'(perr_b), EXP_PROT);
        check("a_prot_clean", 32'(perr_a), 32'd0);
        rstn[1] = 1'b0;
        #1;
        check("b_prot_rst", 32'(perr_b), 32'd0);
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
